// File: rtl/window_scan_counter_if.sv
// ---------------------------------------------------------------------------
// window_scan_counter_if
//
// Beat channel between the sliding-window scanner and the address generator.
//
// Handshake: a beat transfers on a rising clk edge where out_valid and
// out_ready are both 1. Once out_valid rises it stays high, and every payload
// signal (counter_Row, counter_Col, window_last, frame_last, pad_out) holds
// its value, until that transfer happens. out_ready has no effect while
// out_valid is 0.
//
// Signals:
//   out_valid   scanner -> sink   payload holds a valid beat
//   out_ready   sink -> scanner   sink accepts the current beat
//   counter_Row scanner -> sink   pixel row of the beat
//   counter_Col scanner -> sink   pixel column of the beat
//   window_last scanner -> sink   last beat of its kernel window
//   frame_last  scanner -> sink   last beat of the scan
//   pad_out     scanner -> sink   beat is a padding position
//
// Modports: master (scanner side), slave (sink side).
// ---------------------------------------------------------------------------
interface window_scan_counter_if #(
    parameter int ADDR_W = 15
) ();
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] counter_Row;
    logic [ADDR_W-1:0] counter_Col;
    logic              window_last;
    logic              frame_last;
    logic              pad_out;

    modport master (
        output out_valid,
        output counter_Row,
        output counter_Col,
        output window_last,
        output frame_last,
        output pad_out,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  counter_Row,
        input  counter_Col,
        input  window_last,
        input  frame_last,
        input  pad_out,
        output out_ready
    );
endinterface

// File: rtl/window_scan_counter.sv
// ---------------------------------------------------------------------------
// window_scan_counter
//
// Walks every KxK kernel window of a feature map in raster order and emits
// one (row, column) pixel coordinate per accepted beat. Loop order, fastest
// first: kx, ky, ox, oy. Coordinate = (oy*STRIDE + ky, ox*STRIDE + kx).
//
// Optional build macro SCAN_PAD_EN: "same" zero padding with P = (K-1)/2.
// Out-of-map positions are still emitted, flagged with pad_out=1 and a
// (0,0) coordinate. Without the macro no padding logic exists and pad_out
// is tied 0.
//
// Parameters: K (1..7), STRIDE (1..4), ADDR_W (coordinate width).
//
// Ports:
//   clk       in   rising-edge clock
//   reset_n   in   asynchronous active-low reset
//   start     in   scan request, sampled only in IDLE
//   fm_rows   in   feature-map height, captured on accepted start
//   fm_cols   in   feature-map width, captured on accepted start
//   out_if    master modport of the beat channel (see interface header)
//   busy      out  high while scanning
//   done      out  one-cycle pulse when the scan ends
//   cfg_err   out  sticky, dimensions not scannable; cleared by next start
//   state_dbg out  current FSM state (IDLE=0, SCAN=1, DONE=2)
// ---------------------------------------------------------------------------
module window_scan_counter #(
    parameter int K      = 3,
    parameter int STRIDE = 1,
    parameter int ADDR_W = 15
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     fm_rows,
    input  logic [ADDR_W-1:0]     fm_cols,
    window_scan_counter_if.master out_if,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err,
    output logic [1:0]            state_dbg
);

    // Counters carry one spare bit over the coordinate width.
    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0] K_C   = CW'(K);
    localparam logic [CW-1:0] KM1_C = CW'(K - 1);
    localparam logic [CW-1:0] S_C   = CW'(STRIDE);
    localparam logic [CW-1:0] ONE_C = CW'(1);

`ifdef SCAN_PAD_EN
    // Signed arithmetic for padded coordinates needs one more bit so that
    // oy*STRIDE + ky (up to fm-1+P) never wraps into the sign bit.
    localparam int XW = CW + 1;
    localparam logic signed [XW-1:0] S_X = XW'(STRIDE);
    localparam logic signed [XW-1:0] P_X = XW'((K - 1) / 2);
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Counters describe the beat currently presented on the channel.
    logic [CW-1:0] oy_q, ox_q, ky_q, kx_q;
    logic [CW-1:0] oy_d, ox_d, ky_d, kx_d;
    logic [CW-1:0] oy_lim_q, ox_lim_q, oy_lim_d, ox_lim_d;

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] row_q, row_d, col_q, col_d;
    logic              wl_q, wl_d, fl_q, fl_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

`ifdef SCAN_PAD_EN
    logic [ADDR_W-1:0]      rows_q, rows_d, cols_q, cols_d;
    logic                   pad_q, pad_d;
    logic                   pad_n;
    logic signed [XW-1:0]   r_s, c_s;
`endif

    logic              dims_ok;
    logic [CW-1:0]     oy_lim_in, ox_lim_in;
    logic [CW-1:0]     oy_a, ox_a, ky_a, kx_a;
    logic              load_beat;
    logic              wl_n, fl_n;
    logic [ADDR_W-1:0] row_n, col_n;

    // Dimension check and last-window index from the raw start inputs. The
    // limits are only loaded when dims_ok, so their value for bad inputs is
    // irrelevant.
    always_comb begin
`ifdef SCAN_PAD_EN
        dims_ok   = (fm_rows != '0) && (fm_cols != '0);
        oy_lim_in = ({1'b0, fm_rows} - ONE_C) / S_C;
        ox_lim_in = ({1'b0, fm_cols} - ONE_C) / S_C;
`else
        dims_ok   = ({1'b0, fm_rows} >= K_C) && ({1'b0, fm_cols} >= K_C);
        oy_lim_in = ({1'b0, fm_rows} - K_C) / S_C;
        ox_lim_in = ({1'b0, fm_cols} - K_C) / S_C;
`endif
    end

    // Counter successor in kx -> ky -> ox -> oy order. oy never wraps: the
    // frame_last beat leaves SCAN before its successor would be used.
    always_comb begin
        kx_a = kx_q + ONE_C;
        ky_a = ky_q;
        ox_a = ox_q;
        oy_a = oy_q;
        if (kx_q == KM1_C) begin
            kx_a = '0;
            ky_a = ky_q + ONE_C;
            if (ky_q == KM1_C) begin
                ky_a = '0;
                ox_a = ox_q + ONE_C;
                if (ox_q == ox_lim_q) begin
                    ox_a = '0;
                    oy_a = oy_q + ONE_C;
                end
            end
        end
    end

    // FSM next state plus next values of every registered output. Beat
    // payload is evaluated from the counter values being loaded (_d), so
    // the registered outputs always match the registered counters.
    always_comb begin
        state_d   = state_q;
        oy_d      = oy_q;
        ox_d      = ox_q;
        ky_d      = ky_q;
        kx_d      = kx_q;
        oy_lim_d  = oy_lim_q;
        ox_lim_d  = ox_lim_q;
        valid_d   = valid_q;
        row_d     = row_q;
        col_d     = col_q;
        wl_d      = wl_q;
        fl_d      = fl_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        load_beat = 1'b0;
`ifdef SCAN_PAD_EN
        rows_d    = rows_q;
        cols_d    = cols_q;
        pad_d     = pad_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    err_d = 1'b0;
                    oy_d  = '0;
                    ox_d  = '0;
                    ky_d  = '0;
                    kx_d  = '0;
`ifdef SCAN_PAD_EN
                    rows_d = fm_rows;
                    cols_d = fm_cols;
`endif
                    if (dims_ok) begin
                        state_d   = SCAN;
                        oy_lim_d  = oy_lim_in;
                        ox_lim_d  = ox_lim_in;
                        busy_d    = 1'b1;
                        valid_d   = 1'b1;
                        load_beat = 1'b1;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (valid_q && out_if.out_ready) begin
                    if (fl_q) begin
                        state_d = DONE;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        wl_d    = 1'b0;
                        fl_d    = 1'b0;
`ifdef SCAN_PAD_EN
                        pad_d   = 1'b0;
`endif
                    end else begin
                        oy_d      = oy_a;
                        ox_d      = ox_a;
                        ky_d      = ky_a;
                        kx_d      = kx_a;
                        load_beat = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        wl_n = (ky_d == KM1_C) && (kx_d == KM1_C);
        fl_n = wl_n && (oy_d == oy_lim_d) && (ox_d == ox_lim_d);
`ifdef SCAN_PAD_EN
        r_s   = $signed({1'b0, oy_d}) * S_X + $signed({1'b0, ky_d}) - P_X;
        c_s   = $signed({1'b0, ox_d}) * S_X + $signed({1'b0, kx_d}) - P_X;
        pad_n = (r_s < 0) || (r_s >= $signed({2'b00, rows_d})) ||
                (c_s < 0) || (c_s >= $signed({2'b00, cols_d}));
        row_n = pad_n ? '0 : r_s[ADDR_W-1:0];
        col_n = pad_n ? '0 : c_s[ADDR_W-1:0];
`else
        row_n = ADDR_W'(oy_d * S_C + ky_d);
        col_n = ADDR_W'(ox_d * S_C + kx_d);
`endif

        if (load_beat) begin
            row_d = row_n;
            col_d = col_n;
            wl_d  = wl_n;
            fl_d  = fl_n;
`ifdef SCAN_PAD_EN
            pad_d = pad_n;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            oy_q     <= '0;
            ox_q     <= '0;
            ky_q     <= '0;
            kx_q     <= '0;
            oy_lim_q <= '0;
            ox_lim_q <= '0;
            valid_q  <= 1'b0;
            row_q    <= '0;
            col_q    <= '0;
            wl_q     <= 1'b0;
            fl_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef SCAN_PAD_EN
            rows_q   <= '0;
            cols_q   <= '0;
            pad_q    <= 1'b0;
`endif
        end else begin
            oy_q     <= oy_d;
            ox_q     <= ox_d;
            ky_q     <= ky_d;
            kx_q     <= kx_d;
            oy_lim_q <= oy_lim_d;
            ox_lim_q <= ox_lim_d;
            valid_q  <= valid_d;
            row_q    <= row_d;
            col_q    <= col_d;
            wl_q     <= wl_d;
            fl_q     <= fl_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
`ifdef SCAN_PAD_EN
            rows_q   <= rows_d;
            cols_q   <= cols_d;
            pad_q    <= pad_d;
`endif
        end
    end

    assign out_if.out_valid   = valid_q;
    assign out_if.counter_Row = row_q;
    assign out_if.counter_Col = col_q;
    assign out_if.window_last = wl_q;
    assign out_if.frame_last  = fl_q;
`ifdef SCAN_PAD_EN
    assign out_if.pad_out     = pad_q;
`else
    assign out_if.pad_out     = 1'b0;
`endif
    assign busy      = busy_q;
    assign done      = done_q;
    assign cfg_err   = err_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_window_scan_counter.sv
// ---------------------------------------------------------------------------
// tb_window_scan_counter
//
// Directed bench for window_scan_counter. Instance a: K=3, STRIDE=1.
// Instance b: K=3, STRIDE=2. Expected beats come from a nested-loop
// reference model plus hand-computed spot values.
// Beat word layout: {pad, frame_last, window_last, row[14:0], col[14:0]}.
// ---------------------------------------------------------------------------
module tb_window_scan_counter;

    localparam int ADDR_W = 15;

    logic clk;
    logic reset_n;
    logic start_r;
    logic [ADDR_W-1:0] rows_r, cols_r;
    logic rdy;
    int   sel;

    logic start_a, start_b;
    logic busy_a, done_a, err_a, busy_b, done_b, err_b;
    logic [1:0] st_a, st_b;

    window_scan_counter_if #(.ADDR_W(ADDR_W)) if_a ();
    window_scan_counter_if #(.ADDR_W(ADDR_W)) if_b ();

    window_scan_counter #(.K(3), .STRIDE(1), .ADDR_W(ADDR_W)) dut_a (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start_a),
        .fm_rows   (rows_r),
        .fm_cols   (cols_r),
        .out_if    (if_a.master),
        .busy      (busy_a),
        .done      (done_a),
        .cfg_err   (err_a),
        .state_dbg (st_a)
    );

    window_scan_counter #(.K(3), .STRIDE(2), .ADDR_W(ADDR_W)) dut_b (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start_b),
        .fm_rows   (rows_r),
        .fm_cols   (cols_r),
        .out_if    (if_b.master),
        .busy      (busy_b),
        .done      (done_b),
        .cfg_err   (err_b),
        .state_dbg (st_b)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- stimulus routing / observation ----------------
    logic        obs_valid, obs_busy, obs_done, obs_err;
    logic [1:0]  obs_state;
    logic [63:0] obs_beat;

    always_comb begin
        start_a        = (sel == 0) && start_r;
        start_b        = (sel == 1) && start_r;
        if_a.out_ready = (sel == 0) && rdy;
        if_b.out_ready = (sel == 1) && rdy;
        if (sel == 1) begin
            obs_valid = if_b.out_valid;
            obs_busy  = busy_b;
            obs_done  = done_b;
            obs_err   = err_b;
            obs_state = st_b;
            obs_beat  = {31'd0, if_b.pad_out, if_b.frame_last, if_b.window_last,
                         if_b.counter_Row, if_b.counter_Col};
        end else begin
            obs_valid = if_a.out_valid;
            obs_busy  = busy_a;
            obs_done  = done_a;
            obs_err   = err_a;
            obs_state = st_a;
            obs_beat  = {31'd0, if_a.pad_out, if_a.frame_last, if_a.window_last,
                         if_a.counter_Row, if_a.counter_Col};
        end
    end

    // ---------------- scoreboard ----------------
    logic [63:0] exp_q[$];
    logic [63:0] got [0:199];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic pd, input logic fl, input logic wl,
                                       input int row, input int col);
        logic [14:0] r15, c15;
        r15 = row[14:0];
        c15 = col[14:0];
        return {31'd0, pd, fl, wl, r15, c15};
    endfunction

    // Reference model: nested raster loops over windows and kernel taps.
    task automatic build_exp(input int rows, input int cols, input int k, input int s);
        int p, ny, nx, r, c;
        logic pd;
        logic [63:0] last;
        exp_q.delete();
`ifdef SCAN_PAD_EN
        p  = (k - 1) / 2;
        ny = (rows + s - 1) / s;
        nx = (cols + s - 1) / s;
`else
        p  = 0;
        ny = (rows - k) / s + 1;
        nx = (cols - k) / s + 1;
`endif
        for (int oy = 0; oy < ny; oy++)
            for (int ox = 0; ox < nx; ox++)
                for (int ky = 0; ky < k; ky++)
                    for (int kx = 0; kx < k; kx++) begin
                        r  = oy * s - p + ky;
                        c  = ox * s - p + kx;
                        pd = (r < 0) || (r >= rows) || (c < 0) || (c >= cols);
                        exp_q.push_back(mk(pd, 1'b0, (ky == k-1) && (kx == k-1),
                                           pd ? 0 : r, pd ? 0 : c));
                    end
        last = exp_q.pop_back();
        exp_q.push_back(last | (64'd1 << 31));
    endtask

    // ---------------- driver tasks (start and end on a negedge) ----------------
    task automatic pulse_start(input int rows, input int cols);
        rows_r  = rows[ADDR_W-1:0];
        cols_r  = cols[ADDR_W-1:0];
        start_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
    endtask

    // Full scan with optional 1-in-3 ready pattern; beats land in got[].
    task automatic run_scan(input int which, input int rows, input int cols,
                            input int k, input int s, input int stall);
        int n_exp, hs, exp_cycles;
        bit done_seen, hold;
        logic [63:0] prev, e;
        sel = which;
        build_exp(rows, cols, k, s);
        n_exp      = exp_q.size();
        exp_cycles = stall ? 3 * n_exp : n_exp;
        hs = 0; done_seen = 0; hold = 0; prev = '0;
        pulse_start(rows, cols);
        for (int idx = 0; idx < 1000; idx++) begin
            if (idx == 0) begin
                check_eq("first_valid", {63'd0, obs_valid}, 64'd1);
                check_eq("first_busy", {63'd0, obs_busy}, 64'd1);
                check_eq("err_cleared", {63'd0, obs_err}, 64'd0);
            end
            if (obs_done) begin
                done_seen = 1;
                check_eq("done_cycle", idx, exp_cycles);
                check_eq("done_valid", {63'd0, obs_valid}, 64'd0);
                check_eq("done_busy", {63'd0, obs_busy}, 64'd0);
                break;
            end
            if (hold) check_eq("stall_hold", obs_beat, prev);
            rdy = stall ? (idx % 3 == 2) : 1'b1;
            if (obs_valid && rdy) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hDEAD;
                check_eq("beat", obs_beat, e);
                if (hs < 200) got[hs] = obs_beat;
                hs++;
                hold = 0;
            end else if (obs_valid) begin
                hold = 1;
                prev = obs_beat;
            end
            @(negedge clk);
        end
        rdy = 1'b0;
        check_eq("done_seen", {63'd0, done_seen}, 64'd1);
        check_eq("beat_count", hs, n_exp);
        @(negedge clk);
        check_eq("done_pulse_end", {63'd0, obs_done}, 64'd0);
        check_eq("back_to_idle", {62'd0, obs_state}, 64'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int hs;
        reset_n = 1'b0;
        start_r = 1'b0;
        rows_r  = '0;
        cols_r  = '0;
        rdy     = 1'b0;
        sel     = 0;
        repeat (2) @(negedge clk);

        check_eq("rst_valid", {63'd0, if_a.out_valid}, 64'd0);
        check_eq("rst_beat", obs_beat, 64'd0);
        check_eq("rst_busy_done_err", {61'd0, busy_a, done_a, err_a}, 64'd0);
        check_eq("rst_state", {62'd0, st_a}, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

`ifndef SCAN_PAD_EN
        // Basic scan, 4x4, K=3, STRIDE=1.
        run_scan(0, 4, 4, 3, 1, 0);
        check_eq("basic_b1", got[0], mk(0, 0, 0, 0, 0));
        check_eq("basic_b9", got[8], mk(0, 0, 1, 2, 2));
        check_eq("basic_b10", got[9], mk(0, 0, 0, 0, 1));
        check_eq("basic_b36", got[35], mk(0, 1, 1, 3, 3));

        // Backpressure: same map, ready 1 of every 3 cycles.
        run_scan(0, 4, 4, 3, 1, 1);
        check_eq("bp_b10", got[9], mk(0, 0, 0, 0, 1));
        check_eq("bp_b36", got[35], mk(0, 1, 1, 3, 3));

        // Stride 2, 5x5.
        run_scan(1, 5, 5, 3, 2, 0);
        check_eq("s2_w2", got[9], mk(0, 0, 0, 0, 2));
        check_eq("s2_w3", got[18], mk(0, 0, 0, 2, 0));
        check_eq("s2_last", got[35], mk(0, 1, 1, 4, 4));

        // Invalid configuration: 2 rows < K.
        sel = 0;
        pulse_start(2, 8);
`else
        run_scan(0, 3, 3, 3, 1, 0);
        check_eq("pad_b1", got[0], mk(1, 0, 0, 0, 0));
        check_eq("pad_b5", got[4], mk(0, 0, 0, 0, 0));
        check_eq("pad_centre", got[40], mk(0, 0, 0, 1, 1));
        check_eq("pad_last", got[80], mk(1, 1, 1, 0, 0));
        run_scan(0, 4, 4, 3, 1, 1);
        run_scan(1, 5, 5, 3, 2, 0);
        sel = 0;
        pulse_start(0, 8);
`endif
        check_eq("inv_done", {63'd0, obs_done}, 64'd1);
        check_eq("inv_err", {63'd0, obs_err}, 64'd1);
        check_eq("inv_valid", {63'd0, obs_valid}, 64'd0);
        check_eq("inv_busy", {63'd0, obs_busy}, 64'd0);
        @(negedge clk);
        check_eq("inv_done_end", {63'd0, obs_done}, 64'd0);
        check_eq("inv_err_sticky", {63'd0, obs_err}, 64'd1);
        check_eq("inv_idle", {62'd0, obs_state}, 64'd0);
        run_scan(0, 4, 4, 3, 1, 0);

        // Reset after 5 beats of a scan.
        sel = 0;
        pulse_start(4, 4);
        hs = 0;
        for (int i = 0; i < 50 && hs < 5; i++) begin
            rdy = 1'b1;
            if (obs_valid) hs++;
            @(negedge clk);
        end
        check_eq("pre_rst_beats", hs, 5);
        check_eq("pre_rst_b6", obs_beat, mk(0, 0, 0, 1, 2));
        #2 reset_n = 1'b0;
        #1;
        check_eq("arst_valid", {63'd0, obs_valid}, 64'd0);
        check_eq("arst_beat", obs_beat, 64'd0);
        check_eq("arst_flags", {61'd0, obs_busy, obs_done, obs_err}, 64'd0);
        check_eq("arst_state", {62'd0, obs_state}, 64'd0);
        rdy = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_done", {63'd0, obs_done}, 64'd0);
        run_scan(0, 4, 4, 3, 1, 0);
        check_eq("restart_b1", got[0], 64'd0 | mk(got[0][32], 0, 0, 0, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/window_scan_counter.md
# window_scan_counter

Sliding-window coordinate generator that sits directly upstream of the address generator in the UAV convolution datapath. After a start request it walks every K×K kernel window of a feature map in raster order and emits one (row, column) pixel coordinate per beat on `counter_Row`/`counter_Col`. The downstream stage computes the linear memory address from these coordinates. Flow control uses a valid/ready handshake, so the multi-cycle address stage can stall the scan without losing coordinates.

## Interface
- `K`, 3: kernel size in both dimensions (1..7).
- `STRIDE`, 1: window step in both dimensions (1..4).
- `ADDR_W`, 15: coordinate width; matches the address generator's row/column inputs.

- `clk`  in  1: single clock; all flops rise-edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: single-cycle scan request; sampled only in IDLE.
- `fm_rows`  in  ADDR_W: feature-map height; captured on accepted start.
- `fm_cols`  in  ADDR_W: feature-map width; captured on accepted start.
- `out_ready`  in  1: downstream accepts the current beat.
- `out_valid`  out  1: `counter_Row`/`counter_Col` hold a valid beat.
- `counter_Row`  out  ADDR_W: pixel row of the current beat.
- `counter_Col`  out  ADDR_W: pixel column of the current beat.
- `window_last`  out  1: current beat is the last of its window (ky=K-1, kx=K-1).
- `frame_last`  out  1: current beat is the last of the scan.
- `pad_out`  out  1: beat is a padding position; only driven when SCAN_PAD_EN is defined, otherwise tied 0.
- `busy`  out  1: high in SCAN.
- `done`  out  1: one-cycle pulse when the scan ends.
- `cfg_err`  out  1: sticky; set when the dimensions cannot be scanned; cleared by the next accepted start.

## Operation
- FSM states: IDLE, SCAN, DONE.
- **IDLE:**
  - `start`=1 latches `fm_rows`/`fm_cols`, clears `cfg_err` and zeroes the oy, ox, ky, kx counters.
  - Valid dimensions → SCAN.
  - Invalid dimensions → set `cfg_err` and go to DONE with zero beats.
- **SCAN:**
  - Beat coordinate: `counter_Row` = oy·STRIDE + ky, `counter_Col` = ox·STRIDE + kx.
  - Loop order, fastest first: kx, then ky, then ox, then oy.
  - The counters advance only on a handshake (`out_valid` & `out_ready`).
  - The handshake on the `frame_last` beat → DONE.
- **DONE:** `done`=1 for exactly one cycle, then IDLE.
- **Valid-dimension range (no pad):**
  - Dimensions are valid when fm_rows ≥ K and fm_cols ≥ K.
  - oy runs over 0..⌊(fm_rows−K)/STRIDE⌋; ox likewise using fm_cols.
  - Coordinates never exceed fm−1, so they always fit ADDR_W.
- **Handshake rules:**
  - Once raised, `out_valid` stays high until accepted.
  - `counter_Row`, `counter_Col`, `window_last`, `frame_last` and `pad_out` are stable while `out_valid`=1 and `out_ready`=0.
  - `out_ready` is ignored when `out_valid`=0.
- `start` is ignored in SCAN and DONE; no queuing.
- **Arithmetic:** internal counters are ADDR_W+1 bits wide, signed in pad mode. Outputs are the low ADDR_W bits, and only for in-range coordinates.

## Timing
- Reset values: `out_valid`, `busy`, `done`, `cfg_err`, `window_last`, `frame_last` and `pad_out` are 0; `counter_Row` and `counter_Col` are 0; state is IDLE.
- All outputs are registered.
- `start` accepted at edge N → `busy`=1 and `out_valid`=1 with the first beat from edge N+1.
- Throughput is one beat per cycle while `out_ready`=1.
- Last handshake at edge M → `out_valid`=0, `busy`=0 and `done`=1 from edge M+1; IDLE from edge M+2. A new start is accepted at or after edge M+2.
- Invalid configuration: `done` and `cfg_err` are both 1 from edge N+1.
- A `reset_n` assertion mid-scan clears everything immediately (asynchronously). No `done` pulse is produced.

## Configuration
- **`SCAN_PAD_EN` defined:** "same" zero-padding with P = (K−1)/2.
  - oy runs over 0..⌈fm_rows/STRIDE⌉−1; ox likewise using fm_cols.
  - Signed input coordinate: r = oy·STRIDE − P + ky, c = ox·STRIDE − P + kx.
  - If r or c falls outside the map, the beat is still emitted with `pad_out`=1 and `counter_Row`=`counter_Col`=0.
  - Dimensions are valid when both are ≥ 1.
- **`SCAN_PAD_EN` undefined:** no padding; valid-range behaviour as in Operation; `pad_out` is constant 0 and no padding logic is synthesized.

## Test plan
- **Basic scan:** 4×4 map, K=3, STRIDE=1, no pad, `out_ready`=1 → 36 beats; first beat (0,0); beat 9 is (2,2) with `window_last`; beat 10 is (0,1); beat 36 is (3,3) with `frame_last`; `done` pulse one cycle later.
- **Backpressure:** same configuration with `out_ready` low for 2 of every 3 cycles, mimicking a 3-cycle address stage → identical 36-beat sequence, outputs held stable during stalls, 108 cycles from the first beat to `done`.
- **Stride 2:** 5×5 map, K=3, STRIDE=2 → 4 windows, 36 beats; window 2 starts at (0,2), window 3 at (2,0); last beat (4,4).
- **Invalid configuration:** `fm_rows`=2, `fm_cols`=8, K=3 → no `out_valid`; `done` and `cfg_err` are 1 at N+1; a following valid start clears `cfg_err`.
- **Reset mid-scan:** `reset_n` driven low after beat 5 → all outputs 0 and state IDLE asynchronously; a fresh start restarts at (0,0).
- **Padding (SCAN_PAD_EN):** 3×3 map, K=3 → 81 beats; beat 1 has `pad_out`=1; beat 5 is (0,0) with `pad_out`=0; the 5th beat of the centre window is (1,1).
